// File: rtl/cat_anim_sequencer.sv
// cat_anim_sequencer: frame-paced pose sequencer (wave / blink) for the cat sprite.
// Ports: clk, rst_n (async, active-low), vsync (frame marker), ena_anim, speed[1:0]
//        (step period 8<<speed frames), trig (wave request level);
//        arm_up, eyes_closed, tongue_out, busy, frame_cnt[7:0] (all registered).
// Macro CAT_ANIM_BLINK_EN adds the idle blink (BLINK state, blink counter).
module cat_anim_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       ena_anim,
  input  logic [1:0] speed,
  input  logic       trig,
  output logic       arm_up,
  output logic       eyes_closed,
  output logic       tongue_out,
  output logic       busy,
  output logic [7:0] frame_cnt
);
`ifdef CAT_ANIM_BLINK_EN
  typedef enum logic [1:0] {IDLE, WAVE_UP, WAVE_DOWN, BLINK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAVE_UP, WAVE_DOWN} state_t;
`endif
  state_t     state_q, state_d;
  logic       vsync_q, vsync_d;
  logic       armed_q, armed_d;
  logic [7:0] fc_q, fc_d;
  logic [5:0] div_q, div_d;
  logic [1:0] spd_q, spd_d;
  logic       trig_q, trig_d;
  logic       pend_q, pend_d;
  logic [1:0] wave_q, wave_d;
  logic       arm_q, arm_d;
  logic       tongue_q, tongue_d;
  logic       busy_q, busy_d;
  logic       frame_tick, step;
  logic [1:0] spd_eff;
  logic [5:0] lim;
`ifdef CAT_ANIM_BLINK_EN
  logic [3:0] blink_q, blink_d;
  logic       eyes_q, eyes_d;
`endif
  // armed_q blocks a tick on a vsync already high when reset releases
  assign frame_tick = vsync & ~vsync_q & armed_q;
  // speed is taken live only at the start of a divider period
  assign spd_eff = (div_q == 6'd0) ? speed : spd_q;
  assign lim = (spd_eff == 2'd0) ? 6'd7 : (spd_eff == 2'd1) ? 6'd15 : (spd_eff == 2'd2) ? 6'd31 : 6'd63;
  assign step = frame_tick & (div_q == lim);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      armed_q  <= 1'b0;
      fc_q     <= 8'd0;
      div_q    <= 6'd0;
      spd_q    <= 2'd0;
      trig_q   <= 1'b0;
      pend_q   <= 1'b0;
      wave_q   <= 2'd0;
      arm_q    <= 1'b0;
      tongue_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CAT_ANIM_BLINK_EN
      blink_q  <= 4'd0;
      eyes_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_d;
      armed_q  <= armed_d;
      fc_q     <= fc_d;
      div_q    <= div_d;
      spd_q    <= spd_d;
      trig_q   <= trig_d;
      pend_q   <= pend_d;
      wave_q   <= wave_d;
      arm_q    <= arm_d;
      tongue_q <= tongue_d;
      busy_q   <= busy_d;
`ifdef CAT_ANIM_BLINK_EN
      blink_q  <= blink_d;
      eyes_q   <= eyes_d;
`endif
    end
  end
  always_comb begin
    vsync_d = vsync;
    armed_d = armed_q | ~vsync;
    fc_d    = frame_tick ? fc_q + 8'd1 : fc_q;
    spd_d   = spd_eff;
    div_d   = step ? 6'd0 : frame_tick ? div_q + 6'd1 : div_q;
    trig_d  = frame_tick ? trig : trig_q;
    pend_d  = pend_q | (frame_tick & trig & trig_q);
    wave_d  = wave_q;
    state_d = state_q;
`ifdef CAT_ANIM_BLINK_EN
    blink_d = blink_q;
`endif
    if (step) begin
      case (state_q)
        IDLE: begin
          if (pend_q & ena_anim) begin
            state_d = WAVE_UP;
            wave_d  = 2'd0;
            pend_d  = 1'b0;
`ifdef CAT_ANIM_BLINK_EN
            blink_d = 4'd0;
          end else if (blink_q == 4'd15) begin
            state_d = BLINK;
            blink_d = 4'd0;
          end else begin
            blink_d = blink_q + 4'd1;
`endif
          end
        end
        WAVE_UP: state_d = WAVE_DOWN;
        WAVE_DOWN: begin
          state_d = (wave_q == 2'd3) ? IDLE : WAVE_UP;
          wave_d  = wave_q + 2'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    // disabling is immediate, not frame-aligned
    if (!ena_anim) begin
      state_d = IDLE;
      div_d   = 6'd0;
      wave_d  = 2'd0;
      pend_d  = 1'b0;
`ifdef CAT_ANIM_BLINK_EN
      blink_d = 4'd0;
`endif
    end
  end
  // state only moves on step or disable, so decoding state_d keeps outputs frame-stable
  always_comb begin
    arm_d    = state_d == WAVE_UP;
    tongue_d = (state_d == WAVE_UP) | (state_d == WAVE_DOWN);
    busy_d   = state_d != IDLE;
`ifdef CAT_ANIM_BLINK_EN
    eyes_d   = state_d == BLINK;
`endif
  end
  assign arm_up     = arm_q;
  assign tongue_out = tongue_q;
  assign busy       = busy_q;
  assign frame_cnt  = fc_q;
`ifdef CAT_ANIM_BLINK_EN
  assign eyes_closed = eyes_q;
`else
  assign eyes_closed = 1'b0;
`endif
endmodule
